// File: rtl/frame_tx_sched.sv
// Transmit frame scheduler: round-robin grant of two 24-bit payload sources, then serialises
// {HEADER, payload, CHK} LSB-first with a per-bit strobe. Optional FRAME_CNT_EN adds tx_frame_cnt.
module frame_tx_sched #(
    parameter logic [7:0]  HEADER   = 8'b1100_1100,
    parameter int unsigned BIT_DIV  = 5,
    parameter int unsigned GAP_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        ser_o,
    output logic        bit_flag,
    output logic        busy,
`ifdef FRAME_CNT_EN
    output logic [15:0] tx_frame_cnt,
`endif
    output logic        frame_done
);

    localparam int unsigned DIV_W    = $clog2(BIT_DIV);
    localparam int unsigned GAP_LEN  = GAP_BITS * BIT_DIV;
    localparam int unsigned GAP_W    = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    localparam int unsigned GAP_LASTI = (GAP_LEN == 0) ? 0 : GAP_LEN - 1;

    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(BIT_DIV - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_LASTI);
    localparam logic [5:0]       LAST_BIT = 6'd39;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_gnt0;
    logic             r_gnt1;
    logic             r_ser;
    logic             r_bit_flag;
    logic             r_busy;
    logic             r_frame_done;
    logic             r_prefer1;
    logic [DIV_W-1:0] r_div_cnt;
    logic [5:0]       r_bit_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [39:0]      r_shift;
`ifdef FRAME_CNT_EN
    logic [15:0]      r_frame_cnt;
`endif

    logic        w_pick0;
    logic        w_pick1;
    logic [23:0] w_payload;
    logic [9:0]  w_sum;
    logic [39:0] w_frame;

    // req1 wins when it is alone or when the pointer says it is its turn.
    always_comb begin
        w_pick1   = req1 & (~req0 | r_prefer1);
        w_pick0   = req0 & ~w_pick1;
        w_payload = w_pick1 ? data1 : data0;
        w_sum     = 10'(HEADER) + 10'(w_payload[23:16]) + 10'(w_payload[15:8])
                  + 10'(w_payload[7:0]);
        w_frame   = {HEADER, w_payload, w_sum[7:0]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_ser        <= 1'b0;
            r_bit_flag   <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
            r_prefer1    <= 1'b0;
            r_div_cnt    <= '0;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_shift      <= '0;
`ifdef FRAME_CNT_EN
            r_frame_cnt  <= '0;
`endif
        end else begin
            r_gnt0       <= 1'b0;
            r_gnt1       <= 1'b0;
            r_bit_flag   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pick0 | w_pick1) begin
                        r_gnt0     <= w_pick0;
                        r_gnt1     <= w_pick1;
                        r_prefer1  <= w_pick0;
                        r_shift    <= w_frame;
                        r_ser      <= w_frame[0];
                        r_bit_flag <= 1'b1;
                        r_busy     <= 1'b1;
                        r_div_cnt  <= '0;
                        r_bit_cnt  <= '0;
                        r_state    <= SEND;
                    end
                end
                SEND: begin
                    if (r_div_cnt == LAST_DIV) begin
                        r_div_cnt <= '0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_frame_done <= 1'b1;
                            r_ser        <= 1'b0;
`ifdef FRAME_CNT_EN
                            r_frame_cnt  <= r_frame_cnt + 16'd1;
`endif
                            if (GAP_LEN == 0) begin
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_gap_cnt <= '0;
                                r_state   <= GAP;
                            end
                        end else begin
                            r_bit_cnt  <= r_bit_cnt + 6'd1;
                            r_shift    <= {1'b0, r_shift[39:1]};
                            r_ser      <= r_shift[1];
                            r_bit_flag <= 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == LAST_GAP) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_ser   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0       = r_gnt0;
    assign gnt1       = r_gnt1;
    assign ser_o      = r_ser;
    assign bit_flag   = r_bit_flag;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
`ifdef FRAME_CNT_EN
    assign tx_frame_cnt = r_frame_cnt;
`endif

endmodule
